plant_model: RTL and testbench
==============================

// Module: plant_model
// PURPOSE
//   Discrete-time first-order plant: on each sample strobe, computes
//   y[n+1] = a*y[n] + b*u[n] in signed Q(WIDTH-FRAC).FRAC fixed point.
//   Consumes the PID controller's control output and drives the feedback value
//   back to it, closing the loop on-chip for HIL-style regression.
//   Both products share one multicycle shift-add multiplier, so a sample takes
//   2*WIDTH+1 cycles.
// PARAMETERS
//   WIDTH  32  data/coefficient width, two's complement
//   FRAC   16  fractional bits of a, b, u, y (Q16.16 by default)
// PORTS
//   clk       in   1      single clock; all state changes on rising edge
//   srst      in   1      synchronous reset, active-low (sampled on clk edge)
//   en        in   1      clock enable; low freezes all state, outputs held
//   start     in   1      sample strobe; accepted only when busy==0
//   control   in   WIDTH  plant input u[n], latched on accepted start
//   a_coef    in   WIDTH  pole coefficient a, latched on accepted start
//   b_coef    in   WIDTH  input gain b, latched on accepted start
//   feedback  out  WIDTH  plant state y, registered
//   busy      out  1      high from accepted start until done
//   done      out  1      one-cycle pulse, feedback updated in same cycle
// BEHAVIOUR
//   Reset (srst==0 at edge): state=IDLE, feedback=0, busy=0, done=0, all
//     multiplier/operand registers cleared; overrides en and start.
//   FSM: IDLE -> MUL_A -> MUL_B -> SUM -> IDLE.
//     IDLE : start&en at edge k -> latch u, a, b, y_old; busy=1; goto MUL_A.
//     MUL_A: WIDTH iterations of a*y_old (edges k+1..k+WIDTH), store P_a.
//     MUL_B: WIDTH iterations of b*u (edges k+WIDTH+1..k+2*WIDTH), store P_b.
//     SUM  : edge k+2*WIDTH+1: feedback<=sat(P_a+P_b), done=1, busy=0, IDLE.
//   Latency: feedback/done valid 2*WIDTH+1 enabled cycles after the start edge
//     (65 for WIDTH=32); each en==0 cycle adds exactly one cycle.
//   done is high for exactly one enabled cycle; with en==0 during that cycle it
//     is held (en freezes every register including done).
//   Multiply: signed via magnitudes; unsigned shift-add on |x|,|y|, 2*WIDTH
//     product, negate if signs differ. Scale: take bits [FRAC+WIDTH-1:FRAC]
//     (truncation toward -inf after negation); saturate to
//     [-2^(WIDTH-1), 2^(WIDTH-1)-1] if discarded high bits are not sign copies.
//   Sum: WIDTH+1-bit add of saturated P_a, P_b, then saturate to WIDTH.
//   Magnitude of -2^(WIDTH-1) handled as WIDTH-bit unsigned 2^(WIDTH-1).
//   start while busy: ignored, no queueing; start in the SUM cycle ignored too.
//   start held high continuously: new sample accepted on the edge after done.
//   Inputs changing while busy: no effect (operands already latched).
//   Reset mid-operation: aborts, no done pulse, feedback returns to 0.
// STRUCTURE
//   plant_pkg: state_t enum {IDLE, MUL_A, MUL_B, SUM}; WIDTH/FRAC defaults;
//     SAT_MAX/SAT_MIN constants; sat() function shared with SUM stage.
//   Sub-module seq_mult (one instance, reused for both products):
//     clk, srst, en, load, a, b (WIDTH, signed) -> product (2*WIDTH), ready;
//     WIDTH cycles after load, ready pulses with product stable until next load.
//   Top holds FSM, operand/result registers, scaling and saturation logic.
// TESTING (WIDTH=32, FRAC=16)
//   1 Step: a=0x00008000, b=0x00010000, y=0, u=0x00040000 -> feedback=
//     0x00040000, done at cycle 65 after start; repeat same u -> 0x00060000.
//   2 Sign: a=0, b=0xFFFF0000, u=0x00030000 -> feedback=0xFFFD0000; then
//     a=0xFFFF0000, b=0, u=0 -> 0x00030000.
//   3 Saturate: a=0, b=0x7FFF0000, u=0x7FFF0000 -> 0x7FFFFFFF; b=0x80000000,
//     u=0x7FFF0000 -> 0x80000000.
//   4 Handshake: start pulsed at cycles 1,10,40 after accepted start, and
//     u changed mid-op -> single done at 65, result uses original u; en low 10
//     cycles mid-op -> done at 75.
//   5 Reset: srst=0 at cycle 20 of a sample -> feedback=0, busy=0, no done;
//     next start completes normally with y_old=0.
//   6 Closed loop: connect to PID, a=0x0000E666, b=0x00001999, constant
//     reference -> feedback converges within 1% after 200 samples.

Source files
------------

// File: rtl/plant_pkg.sv
// Shared types and helpers for the first-order plant model.
// Holds the FSM state encoding, default widths and the clamp used by the scaling and sum stages.
package plant_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL_A = 2'd1,
        MUL_B = 2'd2,
        SUM   = 2'd3
    } state_t;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_FRAC  = 16;
    localparam int unsigned SAT_BITS  = 64;

    localparam logic signed [DEF_WIDTH-1:0] SAT_MAX = {1'b0, {(DEF_WIDTH-1){1'b1}}};
    localparam logic signed [DEF_WIDTH-1:0] SAT_MIN = {1'b1, {(DEF_WIDTH-1){1'b0}}};

    // Clamp a wide signed value into the w-bit two's complement range (w < SAT_BITS).
    function automatic logic signed [SAT_BITS-1:0] sat(input logic signed [SAT_BITS-1:0] v,
                                                       input int unsigned w);
        logic signed [SAT_BITS-1:0] hi;
        logic signed [SAT_BITS-1:0] lo;
        hi = $signed((SAT_BITS'(1) << (w - 1)) - SAT_BITS'(1));
        lo = ~hi;
        if (v > hi)
            sat = hi;
        else if (v < lo)
            sat = lo;
        else
            sat = v;
    endfunction

endpackage

// File: rtl/seq_mult.sv
// Multicycle signed shift-add multiplier: magnitudes multiplied over WIDTH cycles, sign applied at the end.
// A new load may coincide with the final iteration of the previous product, which is captured in product.
module seq_mult
    import plant_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic                      clk,
    input  logic                      srst,
    input  logic                      en,
    input  logic                      load,
    input  logic signed [WIDTH-1:0]   a,
    input  logic signed [WIDTH-1:0]   b,
    output logic signed [2*WIDTH-1:0] product,
    output logic                      ready
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0]        mcand_q;
    logic [2*WIDTH-1:0]        acc_q;
    logic [2*WIDTH-1:0]        acc_step;
    logic [WIDTH-1:0]          mplier_q;
    logic [CW-1:0]             cnt_q;
    logic                      neg_q;
    logic signed [2*WIDTH-1:0] prod_q;
    logic                      ready_q;

    // The most negative input maps to the unsigned value 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        mag = x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
    endfunction

    always_comb begin
        acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    always_ff @(posedge clk) begin
        if (!srst) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            prod_q   <= '0;
            ready_q  <= 1'b0;
        end else if (en) begin
            ready_q <= 1'b0;
            if (cnt_q != '0) begin
                acc_q    <= acc_step;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    prod_q  <= neg_q ? -$signed(acc_step) : $signed(acc_step);
                    ready_q <= 1'b1;
                end
            end
            if (load) begin
                acc_q    <= '0;
                mcand_q  <= {{WIDTH{1'b0}}, mag(a)};
                mplier_q <= mag(b);
                neg_q    <= a[WIDTH-1] ^ b[WIDTH-1];
                cnt_q    <= CW'(WIDTH);
            end
        end
    end

    assign product = prod_q;
    assign ready   = ready_q;

endmodule

// File: rtl/plant_model.sv
// First-order plant y[n+1] = sat(a*y[n] + b*u[n]) in signed fixed point, one sample per start strobe.
// One shared multiplier: a*y_old is loaded on the start edge, b*u on the last a*y iteration edge.
module plant_model
    import plant_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned FRAC  = DEF_FRAC
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] control,
    input  logic [WIDTH-1:0] a_coef,
    input  logic [WIDTH-1:0] b_coef,
    output logic [WIDTH-1:0] feedback,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH);

    state_t                    state_q;
    logic [CW-1:0]             cnt_q;
    logic [WIDTH-1:0]          u_q;
    logic [WIDTH-1:0]          b_q;
    logic signed [WIDTH-1:0]   pa_q;
    logic [WIDTH-1:0]          y_q;
    logic                      busy_q;
    logic                      done_q;

    logic                      mul_load;
    logic signed [WIDTH-1:0]   mul_x;
    logic signed [WIDTH-1:0]   mul_y;
    logic signed [2*WIDTH-1:0] mul_prod;
    logic                      mul_ready;

    logic signed [SAT_BITS-1:0] prod_wide;
    logic signed [SAT_BITS-1:0] scaled_wide;
    logic signed [SAT_BITS-1:0] sum_wide;
    logic signed [WIDTH-1:0]    scaled;
    logic                       unused_hi;

    always_comb begin
        mul_load = 1'b0;
        mul_x    = b_q;
        mul_y    = u_q;
        if (state_q == IDLE && start) begin
            mul_load = 1'b1;
            mul_x    = a_coef;
            mul_y    = y_q;
        end else if (state_q == MUL_A && cnt_q == CW'(WIDTH - 1)) begin
            mul_load = 1'b1;
        end
    end

    seq_mult #(
        .WIDTH(WIDTH)
    ) u_mult (
        .clk    (clk),
        .srst   (srst),
        .en     (en),
        .load   (mul_load),
        .a      (mul_x),
        .b      (mul_y),
        .product(mul_prod),
        .ready  (mul_ready)
    );

    // Arithmetic shift floors the product; the clamp catches non-sign-copy high bits.
    always_comb begin
        prod_wide   = SAT_BITS'(mul_prod >>> FRAC);
        scaled_wide = sat(prod_wide, WIDTH);
        scaled      = scaled_wide[WIDTH-1:0];
        sum_wide    = sat(SAT_BITS'(pa_q) + SAT_BITS'(scaled), WIDTH);
        unused_hi   = ^{scaled_wide[SAT_BITS-1:WIDTH], sum_wide[SAT_BITS-1:WIDTH]};
    end

    always_ff @(posedge clk) begin
        if (!srst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            u_q     <= '0;
            b_q     <= '0;
            pa_q    <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (en) begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        u_q     <= control;
                        b_q     <= b_coef;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= MUL_A;
                    end
                end
                MUL_A: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        cnt_q   <= '0;
                        state_q <= MUL_B;
                    end
                end
                MUL_B: begin
                    if (mul_ready)
                        pa_q <= scaled;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1))
                        state_q <= SUM;
                end
                SUM: begin
                    y_q     <= sum_wide[WIDTH-1:0];
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign feedback = y_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_plant_model.sv
// Self-checking bench for plant_model: per-cycle comparison against a sample-level arithmetic model,
// directed literal cases (step, sign, saturation, handshake, reset, convergence) and a random phase.
module tb_plant_model;

    localparam int W   = 32;
    localparam int LAT = 2 * W + 1;

    logic        clk = 1'b0;
    logic        srst = 1'b0;
    logic        en = 1'b1;
    logic        start = 1'b0;
    logic [31:0] control = '0;
    logic [31:0] a_coef = '0;
    logic [31:0] b_coef = '0;
    logic [31:0] feedback;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

    logic signed [31:0] m_y = '0;
    logic signed [31:0] m_a, m_b, m_u, m_yold;
    int                 m_rem = 0;
    bit                 m_done = 1'b0;

    plant_model #(.WIDTH(32), .FRAC(16)) dut (
        .clk     (clk),
        .srst    (srst),
        .en      (en),
        .start   (start),
        .control (control),
        .a_coef  (a_coef),
        .b_coef  (b_coef),
        .feedback(feedback),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    function automatic logic signed [31:0] clamp32(input longint v);
        logic [63:0] t;
        if (v > 64'sd2147483647) return 32'h7FFFFFFF;
        if (v < -64'sd2147483648) return 32'h80000000;
        t = v;
        return t[31:0];
    endfunction

    function automatic logic signed [31:0] mulq(input logic signed [31:0] x, input logic signed [31:0] y);
        longint p;
        p = longint'(x) * longint'(y);
        return clamp32(p >>> 16);
    endfunction

    function automatic logic signed [31:0] plant_step(input logic signed [31:0] a, input logic signed [31:0] b,
                                                      input logic signed [31:0] u, input logic signed [31:0] y);
        return clamp32(longint'(mulq(a, y)) + longint'(mulq(b, u)));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Sample-level model: a sample finishes LAT enabled edges after acceptance.
    initial forever begin
        @(posedge clk);
        if (!srst) begin
            m_y = '0;
            m_rem = 0;
            m_done = 1'b0;
        end else if (en) begin
            m_done = 1'b0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_y = plant_step(m_a, m_b, m_u, m_yold);
                    m_done = 1'b1;
                end
            end else if (start) begin
                m_a = a_coef;
                m_b = b_coef;
                m_u = control;
                m_yold = m_y;
                m_rem = LAT;
            end
        end
        #1;
        check("feedback", feedback, m_y);
        check("busy", 32'(busy), 32'(m_rem > 0));
        check("done", 32'(done), 32'(m_done));
    end

    task automatic sample(input logic [31:0] a, input logic [31:0] b, input logic [31:0] u,
                          input bit pokes, input int stall_at, input int stall_len,
                          input int exp_lat, input bit chk_lit, input logic [31:0] lit, input string name);
        int lat;
        lat = -1;
        @(posedge clk);
        #3;
        a_coef = a;
        b_coef = b;
        control = u;
        start = 1'b1;
        en = 1'b1;
        @(posedge clk);
        #3;
        start = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            start = pokes && (i == 1 || i == 10 || i == 40);
            en = !(i >= stall_at && i < stall_at + stall_len);
            if (pokes && i == 5) control = $urandom;
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
            #2;
        end
        start = 1'b0;
        en = 1'b1;
        check({name, " latency"}, lat, exp_lat);
        if (chk_lit) begin
            check({name, " dut"}, feedback, lit);
            check({name, " model"}, m_y, lit);
        end
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 5))
            0: return $urandom;
            1: return ($urandom_range(0, 1) != 0) ? 32'h7FFFFFFF : 32'h80000000;
            default: return 32'($urandom_range(0, 32'h80000)) - 32'h40000;
        endcase
    endfunction

    initial begin
        int seen;
        int d;
        repeat (3) @(posedge clk);
        #1;
        check("reset feedback", feedback, 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        check("reset done", 32'(done), 32'h0);
        #2;
        srst = 1'b1;

        sample(32'h00008000, 32'h00010000, 32'h00040000, 0, 0, 0, LAT, 1, 32'h00040000, "step1");
        sample(32'h00008000, 32'h00010000, 32'h00040000, 0, 0, 0, LAT, 1, 32'h00060000, "step2");
        sample(32'h00000000, 32'hFFFF0000, 32'h00030000, 0, 0, 0, LAT, 1, 32'hFFFD0000, "sign1");
        sample(32'hFFFF0000, 32'h00000000, 32'h00000000, 0, 0, 0, LAT, 1, 32'h00030000, "sign2");
        sample(32'h00000000, 32'h7FFF0000, 32'h7FFF0000, 0, 0, 0, LAT, 1, 32'h7FFFFFFF, "satpos");
        sample(32'h00000000, 32'h80000000, 32'h7FFF0000, 0, 0, 0, LAT, 1, 32'h80000000, "satneg");
        sample(32'h00008000, 32'h00010000, 32'h00020000, 1, 0, 0, LAT, 1, 32'hC0020000, "pokes");
        sample(32'h00008000, 32'h00010000, 32'h00020000, 0, 20, 10, LAT + 10, 1, 32'hE0030000, "stall");

        // Reset in the middle of a sample.
        @(posedge clk);
        #3;
        a_coef = 32'h00008000;
        b_coef = 32'h00010000;
        control = 32'h00020000;
        start = 1'b1;
        @(posedge clk);
        #3;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #3;
        srst = 1'b0;
        @(posedge clk);
        #1;
        check("midreset feedback", feedback, 32'h0);
        check("midreset busy", 32'(busy), 32'h0);
        #2;
        srst = 1'b1;
        seen = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check("midreset no done", seen, 0);
        sample(32'h00008000, 32'h00010000, 32'h00020000, 0, 0, 0, LAT, 1, 32'h00020000, "postreset");

        // Constant drive into a 0.9 pole with 0.1 gain settles near 1.0.
        for (int s = 0; s < 200; s++)
            sample(32'h0000E666, 32'h00001999, 32'h00010000, 0, 0, 0, LAT, 0, 32'h0, "converge");
        d = $signed(feedback) - 65536;
        check("converge 1pct", 32'(d <= 655 && d >= -655), 32'h1);

        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #3;
            en = ($urandom_range(0, 7) != 0);
            start = ($urandom_range(0, 3) == 0);
            srst = ($urandom_range(0, 999) != 0);
            a_coef = rand_val();
            b_coef = rand_val();
            control = rand_val();
        end
        @(posedge clk);
        #3;
        srst = 1'b1;
        en = 1'b1;
        start = 1'b0;
        repeat (200) @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
